multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Sequential, parametrised successor to the combinational opcode decoder.
//  Accepts one instruction at a time and latches its decoded controls.
//  Sequences DECODE/EXEC/WAIT/WRITEBACK and handshakes with the iterative MUL/DIV unit.
//  Sits between instruction fetch and the ALU/register file of the i16 core.
// PARAMETERS
//  WORD_WIDTH      16  datapath width; sizes ImmediateOut
//  OPCODE_WIDTH    3   opcode field width; must be >= 3
//  ALU_OP_WIDTH    2   ALUOpcode width; must be >= 1
//  TIMEOUT_CYCLES  32  max cycles in WAIT before abort; must be >= 2
// PORTS
//  Clock              in   1             rising-edge clock
//  ResetN             in   1             asynchronous, active-low reset
//  InstrValid         in   1             instruction present on Opcode/Immediate
//  InstrReady         out  1             unit can accept an instruction (state IDLE)
//  Opcode             in   OPCODE_WIDTH  instruction opcode
//  Immediate          in   WORD_WIDTH    raw immediate field
//  ImmediateOut       out  WORD_WIDTH    latched immediate; LUI: upper-shifted
//  ALUOpcode          out  ALU_OP_WIDTH  0=MUL, 1=DIV, zero-extended
//  UseImmediate       out  1             operand B from ImmediateOut
//  LoadUpperImmediate out  1             LUI in flight
//  ExecStart          out  1             1-cycle start pulse to MUL/DIV unit
//  ExecDone           in   1             MUL/DIV result valid (sampled in WAIT only)
//  RegWrite           out  1             1-cycle writeback strobe
//  UpdateFlags        out  1             1-cycle flag-update strobe, with RegWrite
//  IllegalOp          out  1             1-cycle pulse for an unsupported opcode
//  Timeout            out  1             1-cycle pulse when WAIT aborts
// BEHAVIOUR
//  Opcodes (low 3 bits; upper bits must be 0, else illegal):
//   - 111 MUL, 000 DIV, 001 MULi, 010 DIVi, 011 LUI; 100-110 are illegal.
//  States: IDLE -> DECODE -> {EXEC -> WAIT | WRITEBACK | IDLE}.
//  Reset (ResetN=0, asynchronous, any state):
//   - state=IDLE, all outputs 0 except InstrReady=1, wait counter=0.
//  IDLE:
//   - InstrReady=1.
//   - InstrValid=1 latches Opcode/Immediate; next state DECODE.
//  DECODE (1 cycle):
//   - Drives latched controls; held stable until return to IDLE.
//   - MUL/DIV/MULi/DIVi -> EXEC.
//   - LUI -> WRITEBACK.
//   - illegal -> IllegalOp=1 this cycle, next state IDLE, no writeback.
//  UseImmediate=1 for MULi, DIVi, LUI.
//  LoadUpperImmediate=1 for LUI only.
//  ImmediateOut = Immediate << (WORD_WIDTH/2) for LUI, else Immediate unmodified; bits shifted out are dropped.
//  EXEC (1 cycle): ExecStart=1; next state WAIT; wait counter cleared.
//  WAIT:
//   - Counter increments each cycle.
//   - ExecDone=1 -> WRITEBACK.
//   - Counter reaches TIMEOUT_CYCLES-1 with ExecDone=0 -> Timeout=1, next IDLE, no writeback.
//   - ExecDone and timeout in the same cycle: ExecDone wins, no Timeout pulse.
//  WRITEBACK (1 cycle):
//   - RegWrite=1.
//   - UpdateFlags=1 for MUL/DIV/MULi/DIVi; UpdateFlags=0 for LUI.
//   - next state IDLE.
//  Outside DECODE..WRITEBACK, ALUOpcode/UseImmediate/LoadUpperImmediate=0.
//  Latency, accept to RegWrite:
//   - LUI: 2 cycles.
//   - MUL/DIV: 3 + (cycles until ExecDone).
//  Back-to-back: next instruction accepted the cycle after WRITEBACK.
//  InstrValid is ignored while InstrReady=0.
//  ExecDone outside WAIT is ignored.
//  Reset mid-WAIT: abort immediately; no RegWrite/Timeout pulse; next ExecDone ignored.
// TESTING
//  1. Reset:
//     - ResetN=0 mid-WAIT -> IDLE at once, InstrReady=1, all strobes 0.
//  2. LUI, Immediate=16'h00AB:
//     - IDLE accept -> ImmediateOut=16'hAB00, LoadUpperImmediate=1.
//     - RegWrite at cycle +2, UpdateFlags=0.
//  3. MULi, Imm=5, ExecDone 4 cycles after ExecStart:
//     - ALUOpcode=0, UseImmediate=1.
//     - RegWrite+UpdateFlags at cycle +7.
//  4. DIV with ExecDone never asserted:
//     - Timeout pulse after 32 WAIT cycles, no RegWrite, InstrReady=1 next cycle.
//  5. Opcode=3'b101:
//     - IllegalOp pulse in DECODE, no ExecStart/RegWrite, back in IDLE.
//  6. InstrValid held high for MUL then DIV:
//     - Second accepted only after first WRITEBACK.
//     - ExecDone coincident with the timeout cycle -> RegWrite, no Timeout.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: latches one instruction, sequences it through the
// iterative MUL/DIV handshake and strobes writeback for the i16 core.
module multicycle_control_unit #(
  parameter int WORD_WIDTH     = 16,
  parameter int OPCODE_WIDTH   = 3,
  parameter int ALU_OP_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                    Clock,
  input  logic                    ResetN,
  input  logic                    InstrValid,
  output logic                    InstrReady,
  input  logic [OPCODE_WIDTH-1:0] Opcode,
  input  logic [WORD_WIDTH-1:0]   Immediate,
  output logic [WORD_WIDTH-1:0]   ImmediateOut,
  output logic [ALU_OP_WIDTH-1:0] ALUOpcode,
  output logic                    UseImmediate,
  output logic                    LoadUpperImmediate,
  output logic                    ExecStart,
  input  logic                    ExecDone,
  output logic                    RegWrite,
  output logic                    UpdateFlags,
  output logic                    IllegalOp,
  output logic                    Timeout
);

  // state     | meaning
  // IDLE      | ready for an instruction; accepts on InstrValid
  // DECODE    | latched controls driven; illegal opcodes abort here
  // EXEC      | one-cycle start pulse to the MUL/DIV unit
  // WAIT      | waiting for ExecDone, bounded by the wait counter
  // WRITEBACK | one-cycle register write (and flag update unless LUI)

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    WAIT,
    WRITEBACK
  } ctrlState_t;

  localparam int CountWidth = $clog2(TIMEOUT_CYCLES);
  localparam logic [CountWidth-1:0] CountLast = CountWidth'(TIMEOUT_CYCLES - 1);
  localparam int ImmShift = WORD_WIDTH / 2;

  ctrlState_t state;
  ctrlState_t nextState;

  logic [CountWidth-1:0] waitCount;
  logic                  waitLast;
  logic                  accept;
  logic                  inFlight;

  logic decIllegal;
  logic decDiv;
  logic decUseImm;
  logic decLui;

  logic                  illegalQ;
  logic                  divQ;
  logic                  useImmQ;
  logic                  luiQ;
  logic [WORD_WIDTH-1:0] immQ;

  assign accept   = (state == IDLE) && InstrValid;
  assign waitLast = (waitCount == CountLast);
  assign inFlight = (state != IDLE);

  // Any set bit above the 3-bit opcode field makes the instruction illegal.
  always_comb begin
    decIllegal = 1'b0;
    decDiv     = 1'b0;
    decUseImm  = 1'b0;
    decLui     = 1'b0;
    if ((Opcode >> 3) != '0) begin
      decIllegal = 1'b1;
    end else begin
      case (Opcode[2:0])
        3'b111: decDiv = 1'b0;
        3'b000: decDiv = 1'b1;
        3'b001: decUseImm = 1'b1;
        3'b010: begin
          decDiv    = 1'b1;
          decUseImm = 1'b1;
        end
        3'b011: begin
          decLui    = 1'b1;
          decUseImm = 1'b1;
        end
        default: decIllegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      illegalQ <= 1'b0;
      divQ     <= 1'b0;
      useImmQ  <= 1'b0;
      luiQ     <= 1'b0;
      immQ     <= '0;
    end else if (accept) begin
      illegalQ <= decIllegal;
      divQ     <= decDiv;
      useImmQ  <= decUseImm;
      luiQ     <= decLui;
      immQ     <= decLui ? (Immediate << ImmShift) : Immediate;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      waitCount <= '0;
    end else if (state == EXEC) begin
      waitCount <= '0;
    end else if (state == WAIT) begin
      waitCount <= waitCount + 1'b1;
    end
  end

  // ExecDone is tested before the terminal count so a coincident done wins.
  always_comb begin
    nextState   = state;
    InstrReady  = 1'b0;
    ExecStart   = 1'b0;
    RegWrite    = 1'b0;
    UpdateFlags = 1'b0;
    IllegalOp   = 1'b0;
    Timeout     = 1'b0;
    case (state)
      IDLE: begin
        InstrReady = 1'b1;
        if (InstrValid) nextState = DECODE;
      end
      DECODE: begin
        if (illegalQ) begin
          IllegalOp = 1'b1;
          nextState = IDLE;
        end else if (luiQ) begin
          nextState = WRITEBACK;
        end else begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        ExecStart = 1'b1;
        nextState = WAIT;
      end
      WAIT: begin
        if (ExecDone) begin
          nextState = WRITEBACK;
        end else if (waitLast) begin
          Timeout   = 1'b1;
          nextState = IDLE;
        end
      end
      WRITEBACK: begin
        RegWrite    = 1'b1;
        UpdateFlags = ~luiQ;
        nextState   = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign ALUOpcode          = inFlight ? ALU_OP_WIDTH'(divQ) : '0;
  assign UseImmediate       = inFlight & useImmQ;
  assign LoadUpperImmediate = inFlight & luiQ;
  assign ImmediateOut       = immQ;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: expected strobes (mask + cycle) are queued
// as instructions are issued and popped as the DUT raises them.
module tb_multicycle_control_unit;

  localparam logic [4:0] MskStart = 5'b00001;
  localparam logic [4:0] MskWb    = 5'b00010;
  localparam logic [4:0] MskUf    = 5'b00100;
  localparam logic [4:0] MskTmo   = 5'b01000;
  localparam logic [4:0] MskIll   = 5'b10000;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        InstrValid;
  logic        InstrReady;
  logic [2:0]  Opcode;
  logic [15:0] Immediate;
  logic [15:0] ImmediateOut;
  logic [1:0]  ALUOpcode;
  logic        UseImmediate;
  logic        LoadUpperImmediate;
  logic        ExecStart;
  logic        ExecDone = 1'b0;
  logic        RegWrite;
  logic        UpdateFlags;
  logic        IllegalOp;
  logic        Timeout;

  typedef struct {
    logic [4:0] mask;
    int         cycle;
  } expEvent_t;

  expEvent_t expQ[$];
  expEvent_t ev;
  logic [4:0] obsMask;

  int nCompared   = 0;
  int nMismatched = 0;
  int cycleNum    = 0;
  int doneDelay   = -1;
  int fireCycle   = -1;

  multicycle_control_unit dut (
    .Clock              (Clock),
    .ResetN             (ResetN),
    .InstrValid         (InstrValid),
    .InstrReady         (InstrReady),
    .Opcode             (Opcode),
    .Immediate          (Immediate),
    .ImmediateOut       (ImmediateOut),
    .ALUOpcode          (ALUOpcode),
    .UseImmediate       (UseImmediate),
    .LoadUpperImmediate (LoadUpperImmediate),
    .ExecStart          (ExecStart),
    .ExecDone           (ExecDone),
    .RegWrite           (RegWrite),
    .UpdateFlags        (UpdateFlags),
    .IllegalOp          (IllegalOp),
    .Timeout            (Timeout)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cycleNum <= cycleNum + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycleNum);
    end
  endtask

  task automatic pushEv(input logic [4:0] mask, input int cycle);
    expEvent_t e;
    e.mask  = mask;
    e.cycle = cycle;
    expQ.push_back(e);
  endtask

  // MUL/DIV model: ExecDone pulses doneDelay cycles after the ExecStart cycle.
  always @(negedge Clock) begin
    if (ExecStart) fireCycle = (doneDelay >= 0) ? cycleNum + doneDelay : -1;
  end

  always @(posedge Clock) begin
    #1;
    ExecDone = (fireCycle >= 0) && (cycleNum == fireCycle);
  end

  always @(negedge Clock) begin
    obsMask = {IllegalOp, Timeout, UpdateFlags, RegWrite, ExecStart};
    if (obsMask != 5'b0) begin
      if (expQ.size() == 0) begin
        checkVal("unexpectedStrobe", {27'b0, obsMask}, 32'h0);
      end else begin
        ev = expQ.pop_front();
        checkVal("strobeMask", {27'b0, obsMask}, {27'b0, ev.mask});
        checkVal("strobeCycle", cycleNum, ev.cycle);
      end
    end
  end

  task automatic stepToDrive();
    @(posedge Clock);
    #1;
  endtask

  task automatic waitUntilCycle(input int n);
    do @(negedge Clock); while (cycleNum < n);
  endtask

  // Leaves InstrValid high; returns at the start of the DECODE cycle.
  task automatic sendInstr(input logic [2:0] op, input logic [15:0] imm, output int acceptCycle);
    int guard;
    Opcode     = op;
    Immediate  = imm;
    InstrValid = 1'b1;
    guard      = 0;
    @(negedge Clock);
    while (!InstrReady && guard < 100) begin
      @(negedge Clock);
      guard++;
    end
    checkVal("acceptBound", {31'b0, InstrReady}, 32'h1);
    acceptCycle = cycleNum;
    stepToDrive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", nCompared);
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;
    logic [2:0] illegalOps [3];
    illegalOps[0] = 3'b100;
    illegalOps[1] = 3'b101;
    illegalOps[2] = 3'b110;

    ResetN     = 1'b0;
    InstrValid = 1'b0;
    Opcode     = 3'b000;
    Immediate  = 16'h0000;
    repeat (2) @(negedge Clock);
    checkVal("rstReady", {31'b0, InstrReady}, 32'h1);
    checkVal("rstRegWrite", {31'b0, RegWrite}, 32'h0);
    checkVal("rstExecStart", {31'b0, ExecStart}, 32'h0);
    checkVal("rstTimeout", {31'b0, Timeout}, 32'h0);
    checkVal("rstIllegal", {31'b0, IllegalOp}, 32'h0);
    checkVal("rstImmOut", {16'b0, ImmediateOut}, 32'h0);
    checkVal("rstAluOp", {30'b0, ALUOpcode}, 32'h0);
    checkVal("rstLui", {31'b0, LoadUpperImmediate}, 32'h0);
    stepToDrive();
    ResetN = 1'b1;
    repeat (2) stepToDrive();

    // LUI: upper-shifted immediate, writeback two cycles after accept.
    doneDelay = -1;
    sendInstr(3'b011, 16'h00AB, acc);
    InstrValid = 1'b0;
    pushEv(MskWb, acc + 2);
    waitUntilCycle(acc + 1);
    checkVal("luiImmOut", {16'b0, ImmediateOut}, 32'h0000AB00);
    checkVal("luiFlag", {31'b0, LoadUpperImmediate}, 32'h1);
    checkVal("luiUseImm", {31'b0, UseImmediate}, 32'h1);
    waitUntilCycle(acc + 3);
    checkVal("luiIdle", {31'b0, InstrReady}, 32'h1);
    checkVal("luiFlagClear", {31'b0, LoadUpperImmediate}, 32'h0);
    stepToDrive();

    // MULi with ExecDone four cycles after ExecStart.
    doneDelay = 4;
    sendInstr(3'b001, 16'h0005, acc);
    InstrValid = 1'b0;
    pushEv(MskStart, acc + 2);
    pushEv(MskWb | MskUf, acc + 7);
    waitUntilCycle(acc + 1);
    checkVal("muliAluOp", {30'b0, ALUOpcode}, 32'h0);
    checkVal("muliUseImm", {31'b0, UseImmediate}, 32'h1);
    checkVal("muliImmOut", {16'b0, ImmediateOut}, 32'h5);
    checkVal("muliLui", {31'b0, LoadUpperImmediate}, 32'h0);
    waitUntilCycle(acc + 5);
    checkVal("muliUseImmHeld", {31'b0, UseImmediate}, 32'h1);
    waitUntilCycle(acc + 8);
    checkVal("muliIdle", {31'b0, InstrReady}, 32'h1);
    stepToDrive();

    // DIV with no ExecDone: Timeout on the 32nd WAIT cycle.
    doneDelay = -1;
    sendInstr(3'b000, 16'h0077, acc);
    InstrValid = 1'b0;
    pushEv(MskStart, acc + 2);
    pushEv(MskTmo, acc + 34);
    waitUntilCycle(acc + 1);
    checkVal("divAluOp", {30'b0, ALUOpcode}, 32'h1);
    checkVal("divUseImm", {31'b0, UseImmediate}, 32'h0);
    waitUntilCycle(acc + 35);
    checkVal("tmoIdle", {31'b0, InstrReady}, 32'h1);
    checkVal("tmoAluOpClear", {30'b0, ALUOpcode}, 32'h0);
    stepToDrive();

    // Illegal opcodes pulse IllegalOp in DECODE and return to IDLE.
    for (int i = 0; i < 3; i++) begin
      sendInstr(illegalOps[i], 16'h00FF, acc);
      InstrValid = 1'b0;
      pushEv(MskIll, acc + 1);
      waitUntilCycle(acc + 2);
      checkVal($sformatf("illIdle%0d", i), {31'b0, InstrReady}, 32'h1);
      stepToDrive();
    end

    // Back-to-back with InstrValid held: MUL whose ExecDone lands on the
    // timeout cycle, then DIV accepted the cycle after MUL writeback.
    doneDelay = 32;
    sendInstr(3'b111, 16'h0011, acc);
    pushEv(MskStart, acc + 2);
    pushEv(MskWb | MskUf, acc + 35);
    sendInstr(3'b000, 16'h1234, acc2);
    InstrValid = 1'b0;
    doneDelay  = 2;
    checkVal("b2bAccept", acc2, acc + 36);
    pushEv(MskStart, acc2 + 2);
    pushEv(MskWb | MskUf, acc2 + 5);
    waitUntilCycle(acc2 + 1);
    checkVal("b2bAluOp", {30'b0, ALUOpcode}, 32'h1);
    checkVal("b2bImmOut", {16'b0, ImmediateOut}, 32'h1234);
    waitUntilCycle(acc2 + 6);
    stepToDrive();

    // Reset mid-WAIT; the late ExecDone must be ignored afterwards.
    doneDelay = 10;
    sendInstr(3'b111, 16'h0003, acc);
    InstrValid = 1'b0;
    pushEv(MskStart, acc + 2);
    waitUntilCycle(acc + 5);
    stepToDrive();
    ResetN = 1'b0;
    #1;
    checkVal("midRstReady", {31'b0, InstrReady}, 32'h1);
    checkVal("midRstRegWrite", {31'b0, RegWrite}, 32'h0);
    checkVal("midRstTimeout", {31'b0, Timeout}, 32'h0);
    checkVal("midRstExecStart", {31'b0, ExecStart}, 32'h0);
    checkVal("midRstAluOp", {30'b0, ALUOpcode}, 32'h0);
    stepToDrive();
    ResetN = 1'b1;
    waitUntilCycle(acc + 45);
    checkVal("postRstReady", {31'b0, InstrReady}, 32'h1);
    checkVal("queueDrained", expQ.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
